// File: rtl/pipe_stage_skid_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_stage_skid_if : valid/ready handshake bundle for the two-entry skid stage
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
interface pipe_stage_skid_if #(
  parameter int DATA_W = 32
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  // master: producer on the input side and consumer on the output side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_stage_skid : two-entry (head + skid) pipeline stage with registered
//                   in_ready, flush/freeze control and optional perf counters.
//                   Perf counters built only when PIPE_STAGE_SKID_PERF_EN is defined.
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_b,
  input  wire logic             flush,
  input  wire logic             freeze,
  pipe_stage_skid_if.slave      bus,
  output logic [1:0]            occupancy,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      xfer_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_skid;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_in_hs;
  logic              w_out_hs;
  logic              w_head_ld_in;
  logic              w_head_ld_skid;
  logic              w_skid_ld;

  // in_ready depends only on state, freeze and reset - never on out_ready
  assign w_in_ready  = (r_state != ST_FULL) && !freeze && rst_b;
  assign w_out_valid = (r_state != ST_EMPTY) && !freeze;
  assign w_in_hs     = bus.in_valid && w_in_ready && !flush;
  assign w_out_hs    = w_out_valid && bus.out_ready && !flush;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_head;
  assign occupancy     = r_state;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next         = r_state;
    w_head_ld_in   = 1'b0;
    w_head_ld_skid = 1'b0;
    w_skid_ld      = 1'b0;
    if (flush) begin
      w_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_hs) begin
            w_head_ld_in = 1'b1;
            w_next       = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_hs && w_out_hs) begin
            w_head_ld_in = 1'b1;
          end else if (w_in_hs) begin
            w_skid_ld = 1'b1;
            w_next    = ST_FULL;
          end else if (w_out_hs) begin
            w_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_out_hs) begin
            w_head_ld_skid = 1'b1;
            w_next         = ST_ONE;
          end
        end
        default: w_next = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_head <= '0;
      r_skid <= '0;
    end else begin
      if (w_head_ld_in) begin
        r_head <= bus.in_data;
      end else if (w_head_ld_skid) begin
        r_head <= r_skid;
      end
      if (w_skid_ld) begin
        r_skid <= bus.in_data;
      end
    end
  end

`ifdef PIPE_STAGE_SKID_PERF_EN
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_xfer_cnt;
  logic             w_stall;

  // a flush cycle is neither a transfer nor a stall, so counters stay put
  assign w_stall = w_out_valid && !bus.out_ready && !flush;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_stall_cnt <= '0;
      r_xfer_cnt  <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + c_cnt_one;
      end
      if (w_out_hs && (r_xfer_cnt != '1)) begin
        r_xfer_cnt <= r_xfer_cnt + c_cnt_one;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign xfer_cnt  = r_xfer_cnt;
`else
  assign stall_cnt = '0;
  assign xfer_cnt  = '0;
`endif

endmodule
`default_nettype wire
